ysyx_23060337_fetch_ctrl: RTL and testbench
===========================================

# ysyx_23060337_fetch_ctrl

Multi-cycle instruction fetch controller sitting directly upstream of the decode unit. It owns the program counter, issues one instruction-memory request at a time over a valid/ready channel, and presents each fetched instruction with its PC to decode over a second valid/ready channel. It also accepts PC redirects (branch, jump, trap) from the execute stage. It replaces the free-running PC register plus combinational fetch with a handshaked fetch stage.

## Interface
- RESET_PC, 32'h80000000, first fetch address after reset

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address, bits [1:0] always 0
- imem_rsp_valid  in  1  response strobe, one cycle per accepted request
- imem_rsp_data  in  32  instruction word
- imem_rsp_err  in  1  access fault for this response
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst  out  32  instruction word to decode
- inst_pc  out  32  PC of inst
- inst_fault  out  1  inst carries an access fault
- redirect_valid  in  1  one-cycle redirect strobe from execute
- redirect_pc  in  32  new PC; bits [1:0] ignored, treated as 00

## Operation
- States: IDLE, REQ, WAIT, OUT. Registers: pc, kill, inst, inst_pc, inst_fault.
- imem_req_valid = (state==REQ) && !redirect_valid; imem_req_addr = {pc[31:2],2'b00}.
- inst_valid = (state==OUT) && !redirect_valid.
- IDLE: go to REQ next cycle. No request is issued from IDLE.
- REQ:
  - redirect_valid: pc <= redirect_pc, stay in REQ. No request is issued.
  - imem_req_valid && imem_req_ready: go to WAIT, kill <= 0.
- WAIT, one outstanding request:
  - redirect_valid without imem_rsp_valid: pc <= redirect_pc, kill <= 1, stay in WAIT.
  - imem_rsp_valid with kill or redirect_valid: discard the response and go to REQ. pc takes redirect_pc if redirect_valid is asserted, else keeps the already-redirected value. kill <= 0.
  - imem_rsp_valid, otherwise: inst <= imem_rsp_data, inst_pc <= pc, inst_fault <= imem_rsp_err, pc <= pc+4, go to OUT.
- OUT:
  - redirect_valid: drop the held instruction, pc <= redirect_pc, go to REQ. No transfer to decode occurs this cycle.
  - inst_ready (inst_valid high): transfer completes, go to REQ.
  - Otherwise hold inst, inst_pc and inst_fault stable.
- Faults do not stop fetch. The faulting word is delivered with inst_fault=1, and fetch continues at pc+4 until execute redirects.
- pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
- imem_rsp_valid outside WAIT is ignored.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, pc=RESET_PC, kill=0, inst=0, inst_pc=0, inst_fault=0. All valid outputs are 0 during reset and in the first cycle after release.
- First request: imem_req_valid=1 in the second cycle after rst rises.
- Minimum fetch-to-fetch period is 3 cycles: REQ accepted, response in the next cycle (WAIT), OUT accepted at once.
- Memory latency is unbounded (≥1 cycle after acceptance). The controller waits in WAIT indefinitely.
- A redirect takes effect in the next cycle. A new request to redirect_pc is driven at the earliest in the cycle after redirect_valid.
- Reset mid-operation aborts any outstanding request. A stale response arriving after reset release (IDLE or REQ) is ignored.
- All outputs are registered except imem_req_valid and inst_valid, which are state decodes gated by redirect_valid.

## Test plan
- Reset release, memory with 1-cycle latency returning 32'h00000413 for each address:
  - imem_req_addr is 32'h80000000, then 32'h80000004.
  - inst_pc follows the same sequence.
  - inst_valid pulses every 3 cycles with inst_ready=1.
- Decode backpressure: hold inst_ready=0 for 5 cycles in OUT.
  - inst, inst_pc and inst_fault stay stable, no new imem request.
  - After inst_ready=1, the next request is to pc+4.
- Redirect in WAIT: memory latency 4, redirect to 32'h80000100 in the second WAIT cycle.
  - The late response is discarded, inst_valid stays 0.
  - The next request is to 32'h80000100.
- Redirect in OUT together with inst_ready=1: no transfer (inst_valid=0 that cycle), next request to redirect_pc. Redirect_pc 32'h80000203 yields address 32'h80000200.
- Fault and wrap:
  - imem_rsp_err=1 at pc 32'hFFFFFFFC delivers inst_fault=1 with inst_pc=32'hFFFFFFFC.
  - The next request is to 32'h00000000.
- Assert rst in WAIT, then release; memory returns a response one cycle after release.
  - The response is ignored.
  - The first delivered inst_pc is 32'h80000000.

Source files
------------

// File: rtl/ysyx_23060337_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_23060337_fetch_ctrl
//
// Multi-cycle instruction fetch controller placed directly upstream of decode.
// It owns the program counter and keeps at most one instruction-memory request
// in flight. Each fetched word is presented to decode together with its PC and
// an access-fault flag. Execute can redirect the PC at any time. The redirect
// discards whatever is in flight or held, and fetch resumes at the new target.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous, active-low reset
//   imem_req_valid  request to instruction memory (REQ state, not redirecting)
//   imem_req_ready  memory accepts the request
//   imem_req_addr   word-aligned fetch address
//   imem_rsp_valid  one-cycle response strobe per accepted request
//   imem_rsp_data   instruction word returned by memory
//   imem_rsp_err    access fault for this response
//   inst_valid      instruction available to decode (OUT state, not redirecting)
//   inst_ready      decode accepts the instruction
//   inst            held instruction word
//   inst_pc         PC of the held instruction
//   inst_fault      held instruction carries an access fault
//   redirect_valid  one-cycle redirect strobe from execute
//   redirect_pc     redirect target; the low two bits are ignored
// ----------------------------------------------------------------------------
module ysyx_23060337_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        kill;
    logic        kill_next;
    logic [31:0] inst_next;
    logic [31:0] inst_pc_next;
    logic        inst_fault_next;
    logic [31:0] redirect_target;

    // Masking with an AND keeps every bit of redirect_pc formally in use while
    // forcing word alignment of the new PC.
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // A redirect in the same cycle suppresses both handshakes. No request leaves
    // with a stale PC, and no instruction from the wrong path reaches decode.
    assign imem_req_valid = (state == S_REQ) && !redirect_valid;
    assign inst_valid     = (state == S_OUT) && !redirect_valid;
    assign imem_req_addr  = {pc[31:2], 2'b00};

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            inst       <= 32'h0;
            inst_pc    <= 32'h0;
            inst_fault <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            kill       <= kill_next;
            inst       <= inst_next;
            inst_pc    <= inst_pc_next;
            inst_fault <= inst_fault_next;
        end
    end

    // Next-state logic.
    // kill records that the PC was redirected while a request was still
    // outstanding. The response to that request must be thrown away when it
    // finally arrives. The memory latency is unbounded, so the controller
    // cannot simply abandon the request.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        kill_next       = kill;
        inst_next       = inst;
        inst_pc_next    = inst_pc;
        inst_fault_next = inst_fault;

        case (state)
            S_IDLE: begin
                state_next = S_REQ;
            end

            S_REQ: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end else if (imem_req_ready) begin
                    state_next = S_WAIT;
                    kill_next  = 1'b0;
                end
            end

            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill || redirect_valid) begin
                        if (redirect_valid) begin
                            pc_next = redirect_target;
                        end
                        kill_next  = 1'b0;
                        state_next = S_REQ;
                    end else begin
                        inst_next       = imem_rsp_data;
                        inst_pc_next    = pc;
                        inst_fault_next = imem_rsp_err;
                        // Faults do not stall fetch. Execute decides when to redirect.
                        pc_next         = pc + 32'd4;
                        state_next      = S_OUT;
                    end
                end else if (redirect_valid) begin
                    pc_next   = redirect_target;
                    kill_next = 1'b1;
                end
            end

            S_OUT: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = S_REQ;
                end else if (inst_ready) begin
                    state_next = S_REQ;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060337_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060337_fetch_ctrl
//
// Self-checking bench for the fetch controller. A behavioural memory with a
// programmable latency answers each accepted request. A scoreboard queue
// holds the instruction that decode is expected to receive next: an entry is
// pushed when a request is accepted and popped on each decode handshake. The
// queue is flushed whenever a redirect is driven.
// ----------------------------------------------------------------------------
module tb_ysyx_23060337_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    logic [31:0] next_req_addr;

    // Memory model state
    int          mem_lat = 1;
    bit          mem_pend = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_data;
    logic        mem_err;
    bit          use_const = 1;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    // Per-step observations
    bit          acc_flag;
    bit          del_flag;
    logic [31:0] last_acc_addr;
    logic [31:0] last_del_pc;
    int          last_del_cycle = 0;
    int          prev_del_cycle = 0;

    ysyx_23060337_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return use_const ? 32'h0000_0413 : (a ^ 32'h5A5A_0413);
    endfunction

    // One clock cycle: drive the inputs just after the edge, let the memory
    // model respond, then sample the outputs and update the scoreboard.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        exp_t e;
        @(posedge clk);
        #1;
        cycle++;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                mem_pend       = 0;
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_data;
                imem_rsp_err   = mem_err;
            end
        end
        #1;
        acc_flag = 0;
        del_flag = 0;
        if (!rst) begin
            checks++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_valids: req_valid=%b inst_valid=%b, expected 0/0",
                         imem_req_valid, inst_valid);
            end
        end else begin
            if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
                checks++;
                if (imem_req_addr !== next_req_addr) begin
                    errors++;
                    $display("[TB] FAIL req_addr: got %h, expected %h", imem_req_addr, next_req_addr);
                end
                e.pc    = next_req_addr;
                e.data  = mem_word(next_req_addr);
                e.fault = (next_req_addr == err_addr);
                sb_q.push_back(e);
                acc_flag      = 1;
                last_acc_addr = imem_req_addr;
                mem_pend      = 1;
                mem_cnt       = mem_lat;
                mem_data      = mem_word(imem_req_addr);
                mem_err       = (imem_req_addr == err_addr);
                next_req_addr = next_req_addr + 32'd4;
            end
            if (rv) begin
                checks++;
                if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL redirect_gating: inst_valid=%b req_valid=%b, expected 0/0",
                             inst_valid, imem_req_valid);
                end
                sb_q.delete();
                next_req_addr = rpc & 32'hFFFF_FFFC;
            end else if (inst_valid === 1'b1 && rdy) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL spurious_inst: got inst_pc=%h, expected no instruction", inst_pc);
                end else begin
                    e = sb_q.pop_front();
                    if (inst !== e.data || inst_pc !== e.pc || inst_fault !== e.fault) begin
                        errors++;
                        $display("[TB] FAIL deliver: got pc=%h inst=%h fault=%b, expected pc=%h inst=%h fault=%b",
                                 inst_pc, inst, inst_fault, e.pc, e.data, e.fault);
                    end
                end
                del_flag       = 1;
                last_del_pc    = inst_pc;
                prev_del_cycle = last_del_cycle;
                last_del_cycle = cycle;
            end
        end
    endtask

    // Step with decode stalled until an instruction is held in OUT.
    task automatic run_to_out();
        bit ok = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (inst_valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout_out: got no inst_valid, expected one within 30 cycles");
        end
    endtask

    task automatic test_reset();
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b/%b, expected 0/0", imem_req_valid, inst_valid);
        end
        checks++;
        if (inst !== 32'h0 || inst_pc !== 32'h0 || inst_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_regs: got inst=%h pc=%h fault=%b, expected zeros", inst, inst_pc, inst_fault);
        end
        checks++;
        if (imem_req_addr !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL reset_addr: got %h, expected %h", imem_req_addr, RESET_PC);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        next_req_addr = RESET_PC;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release_valid: got %b/%b, expected 0/0", imem_req_valid, inst_valid);
        end
        step(1'b1, 1'b0, 32'h0);
        checks++;
        if (!acc_flag) begin
            errors++;
            $display("[TB] FAIL first_req: got req_valid=%b, expected 1", imem_req_valid);
        end
    endtask

    task automatic test_basic();
        int ndel = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (del_flag) begin
                ndel++;
                if (ndel == 1) begin
                    checks++;
                    if (last_del_pc !== RESET_PC) begin
                        errors++;
                        $display("[TB] FAIL first_inst_pc: got %h, expected %h", last_del_pc, RESET_PC);
                    end
                end else begin
                    checks++;
                    if (last_del_cycle - prev_del_cycle != 3) begin
                        errors++;
                        $display("[TB] FAIL period: got %0d, expected 3", last_del_cycle - prev_del_cycle);
                    end
                end
            end
        end
        checks++;
        if (ndel != 4) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d deliveries, expected 4", ndel);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        use_const = 0;
        run_to_out();
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL bp_queue: got empty scoreboard, expected one entry");
            return;
        end
        e = sb_q[0];
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
            checks++;
            if (inst !== e.data || inst_pc !== e.pc || inst_fault !== e.fault ||
                inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold: got pc=%h inst=%h fault=%b v=%b req=%b, expected pc=%h inst=%h fault=%b v=1 req=0",
                         inst_pc, inst, inst_fault, inst_valid, imem_req_valid, e.pc, e.data, e.fault);
            end
        end
        step(1'b1, 1'b0, 32'h0);
        checks++;
        if (!del_flag) begin
            errors++;
            $display("[TB] FAIL bp_release: got no transfer, expected transfer");
        end
        step(1'b1, 1'b0, 32'h0);
        checks++;
        if (!acc_flag || last_acc_addr !== e.pc + 32'd4) begin
            errors++;
            $display("[TB] FAIL bp_next_req: got acc=%b addr=%h, expected acc=1 addr=%h",
                     acc_flag, last_acc_addr, e.pc + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        bit got = 0;
        mem_lat = 4;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (acc_flag) begin
                got = 1;
                break;
            end
        end
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h8000_0100);
        got = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (acc_flag) begin
                got = 1;
                break;
            end
            checks++;
            if (inst_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rw_discard: got inst_valid=%b, expected 0", inst_valid);
            end
        end
        checks++;
        if (!got || last_acc_addr !== 32'h8000_0100) begin
            errors++;
            $display("[TB] FAIL rw_next_req: got acc=%b addr=%h, expected acc=1 addr=80000100", got, last_acc_addr);
        end
        mem_lat = 1;
    endtask

    task automatic test_redirect_out();
        run_to_out();
        step(1'b1, 1'b1, 32'h8000_0203);
        checks++;
        if (del_flag) begin
            errors++;
            $display("[TB] FAIL ro_transfer: got transfer, expected none");
        end
        step(1'b1, 1'b0, 32'h0);
        checks++;
        if (!acc_flag || last_acc_addr !== 32'h8000_0200) begin
            errors++;
            $display("[TB] FAIL ro_next_req: got acc=%b addr=%h, expected acc=1 addr=80000200", acc_flag, last_acc_addr);
        end
    endtask

    task automatic test_fault_wrap();
        bit got = 0;
        err_addr = 32'hFFFF_FFFC;
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (del_flag) begin
                got = 1;
                checks++;
                if (last_del_pc !== 32'hFFFF_FFFC || inst_fault !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL fault_inst: got pc=%h fault=%b, expected pc=fffffffc fault=1", last_del_pc, inst_fault);
                end
                break;
            end
        end
        got = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (acc_flag) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got || last_acc_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_req: got acc=%b addr=%h, expected acc=1 addr=00000000", got, last_acc_addr);
        end
    endtask

    task automatic test_reset_midflight();
        bit got = 0;
        mem_lat = 10;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (acc_flag) break;
        end
        step(1'b1, 1'b0, 32'h0);
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_valid: got %b/%b, expected 0/0", imem_req_valid, inst_valid);
        end
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        rst = 1'b1;
        sb_q.delete();
        next_req_addr = RESET_PC;
        mem_lat  = 1;
        mem_pend = 1;
        mem_cnt  = 1;
        mem_data = 32'hDEAD_BEEF;
        mem_err  = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_release_valid: got %b/%b, expected 0/0", imem_req_valid, inst_valid);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (del_flag) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got || last_del_pc !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL stale_ignored: got del=%b pc=%h, expected del=1 pc=%h", got, last_del_pc, RESET_PC);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_out();
        test_fault_wrap();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
